// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_if
// Desc     : Issue/result handshake bundle between the ALU and the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_ctrl;
    logic [XLEN-1:0] in_op_a;
    logic [XLEN-1:0] in_op_b;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [4:0]      out_rd;
    logic            busy;

    modport master (
        output in_valid, in_alu_ctrl, in_op_a, in_op_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, busy
    );

    modport slave (
        input  in_valid, in_alu_ctrl, in_op_a, in_op_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Desc     : Execute-stage ALU with registered result/zero flag, valid/ready
//            on both sides and an iterative 1-bit-per-cycle shifter.
//            Define ALU_BARREL_SHIFT_EN for a single-cycle barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b1000;
    localparam logic [3:0] c_SLL  = 4'b0001;
    localparam logic [3:0] c_SLT  = 4'b0010;
    localparam logic [3:0] c_SLTU = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SRL  = 4'b0101;
    localparam logic [3:0] c_SRA  = 4'b1101;
    localparam logic [3:0] c_OR   = 4'b0110;
    localparam logic [3:0] c_AND  = 4'b0111;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_is_shift;
    logic            w_lt_s;
    logic            w_lt_u;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_result;
    logic            w_load;
    logic [XLEN-1:0] w_load_result;
    logic [4:0]      w_load_rd;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic            r_out_zero;
    logic [4:0]      r_out_rd;

    assign w_shamt    = bus.in_op_b[SHW-1:0];
    assign w_is_shift = (bus.in_alu_ctrl == c_SLL) || (bus.in_alu_ctrl == c_SRL) ||
                        (bus.in_alu_ctrl == c_SRA);
    assign w_lt_s     = $signed(bus.in_op_a) < $signed(bus.in_op_b);
    assign w_lt_u     = bus.in_op_a < bus.in_op_b;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Single-cycle result; iterative builds only reach the shift items with amount 0.
    always_comb begin
        w_result = bus.in_op_a + bus.in_op_b;
        case (bus.in_alu_ctrl)
            c_SUB:  w_result = bus.in_op_a - bus.in_op_b;
            c_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_s};
            c_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_u};
            c_XOR:  w_result = bus.in_op_a ^ bus.in_op_b;
            c_OR:   w_result = bus.in_op_a | bus.in_op_b;
            c_AND:  w_result = bus.in_op_a & bus.in_op_b;
`ifdef ALU_BARREL_SHIFT_EN
            c_SLL:  w_result = bus.in_op_a << w_shamt;
            c_SRL:  w_result = bus.in_op_a >> w_shamt;
            c_SRA:  w_result = $unsigned($signed(bus.in_op_a) >>> w_shamt);
`else
            c_SLL, c_SRL, c_SRA: w_result = bus.in_op_a;
`endif
            default: w_result = bus.in_op_a + bus.in_op_b;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign w_in_ready    = !rst && (!r_out_valid || bus.out_ready);
    assign bus.busy      = 1'b0;
    assign w_load        = w_accept;
    assign w_load_result = w_result;
    assign w_load_rd     = bus.in_rd;
`else
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [XLEN-1:0] r_work;
    logic [XLEN-1:0] w_work_next;
    logic [XLEN-1:0] w_work_step;
    logic [SHW-1:0]  r_cnt;
    logic [SHW-1:0]  w_cnt_next;
    logic [3:0]      r_sh_ctrl;
    logic [3:0]      w_sh_ctrl_next;
    logic [4:0]      r_sh_rd;
    logic [4:0]      w_sh_rd_next;

    assign w_in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign bus.busy   = (r_state == ST_SHIFT);

    always_comb begin
        case (r_sh_ctrl)
            c_SLL:   w_work_step = {r_work[XLEN-2:0], 1'b0};
            c_SRA:   w_work_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
            default: w_work_step = {1'b0, r_work[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_sh_ctrl <= '0;
            r_sh_rd   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_work    <= w_work_next;
            r_cnt     <= w_cnt_next;
            r_sh_ctrl <= w_sh_ctrl_next;
            r_sh_rd   <= w_sh_rd_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_work_next    = r_work;
        w_cnt_next     = r_cnt;
        w_sh_ctrl_next = r_sh_ctrl;
        w_sh_rd_next   = r_sh_rd;
        w_load         = 1'b0;
        w_load_result  = w_result;
        w_load_rd      = bus.in_rd;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) begin
                        w_state_next   = ST_SHIFT;
                        w_work_next    = bus.in_op_a;
                        w_cnt_next     = w_shamt;
                        w_sh_ctrl_next = bus.in_alu_ctrl;
                        w_sh_rd_next   = bus.in_rd;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                w_work_next = w_work_step;
                w_cnt_next  = r_cnt - SHW'(1);
                // Last step publishes the shifted value directly, saving a cycle.
                if (r_cnt == SHW'(1)) begin
                    w_load        = 1'b1;
                    w_load_result = w_work_step;
                    w_load_rd     = r_sh_rd;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end
`endif

    // Result slot: a new load always wins over a consume in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_rd     <= '0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_load_result;
            r_out_zero   <= (w_load_result == '0);
            r_out_rd     <= w_load_rd;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_zero   = r_out_zero;
    assign bus.out_rd     = r_out_rd;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec
// Desc     : Scoreboard bench for alu_exec (iterative or ALU_BARREL_SHIFT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec;
    localparam int XLEN = 32;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b1000;
    localparam logic [3:0] c_SLL  = 4'b0001;
    localparam logic [3:0] c_SLT  = 4'b0010;
    localparam logic [3:0] c_SLTU = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SRL  = 4'b0101;
    localparam logic [3:0] c_SRA  = 4'b1101;
    localparam logic [3:0] c_OR   = 4'b0110;
    localparam logic [3:0] c_AND  = 4'b0111;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [4:0]  rd;
    } exp_t;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(XLEN)) bus ();

    alu_exec #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            c_SUB:   return a - b;
            c_SLL:   return a << b[4:0];
            c_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            c_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            c_XOR:   return a ^ b;
            c_SRL:   return a >> b[4:0];
            c_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            c_OR:    return a | b;
            c_AND:   return a & b;
            default: return a + b;
        endcase
    endfunction

    // Scoreboard: called once per cycle at the negedge, pops on each consumed result.
    task automatic sb_sample();
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got result=%h rd=%0d, required no output",
                         bus.out_result, bus.out_rd);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_result !== e.result || bus.out_zero !== e.zero ||
                    bus.out_rd !== e.rd) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h/z%b/rd%0d, required %h/z%b/rd%0d",
                             bus.out_result, bus.out_zero, bus.out_rd,
                             e.result, e.zero, e.rd);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and returns just after the edge that accepted it.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int waited);
        logic        accepted;
        logic [31:0] r;
        accepted        = 1'b0;
        waited          = 0;
        bus.in_valid    = 1'b1;
        bus.in_alu_ctrl = c;
        bus.in_op_a     = a;
        bus.in_op_b     = b;
        bus.in_rd       = rd;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            sb_sample();
            if (bus.in_ready) begin
                accepted = 1'b1;
                r = model(c, a, b);
                exp_q.push_back({r, (r == 32'd0), rd});
            end
            @(posedge clk);
            #1;
            if (!accepted) waited++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept in %0d cycles, required accept", waited);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({bus.out_valid, bus.out_zero, bus.out_rd, bus.busy, bus.in_ready} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got v%b z%b rd%0d busy%b rdy%b, required all 0",
                     bus.out_valid, bus.out_zero, bus.out_rd, bus.busy, bus.in_ready);
        end
        n_checks++;
        if (bus.out_result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h, required 00000000", bus.out_result);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_alu_ops();
        int   w;
        vec_t tbl [13] = '{
            {c_ADD,   32'h0000_0005, 32'h0000_0003, 32'h0000_0008},
            {c_SUB,   32'h0000_0007, 32'h0000_0007, 32'h0000_0000},
            {c_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            {c_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            {c_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000},
            {c_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
            {c_XOR,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB},
            {c_OR,    32'hA000_0005, 32'h0000_0A00, 32'hA000_0A05},
            {c_AND,   32'hFFFF_0F0F, 32'h1234_5678, 32'h1234_0608},
            {c_SUB,   32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
            {c_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            {4'b1111, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E},
            {c_SLL,   32'h0000_1234, 32'h0000_0020, 32'h0000_1234}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].ctrl, tbl[i].a, tbl[i].b, 5'(i + 1), w);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== tbl[i].exp ||
                bus.out_zero !== (tbl[i].exp == 32'd0) || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL op_%0d: got v%b %h z%b rdy%b, required v1 %h z%b rdy1", i,
                         bus.out_valid, bus.out_result, bus.out_zero, bus.in_ready,
                         tbl[i].exp, (tbl[i].exp == 32'd0));
            end
        end
    endtask

    task automatic test_shift();
        int   w, edges, busy_cnt, rdy_bad, lat;
        vec_t tbl [4] = '{
            {c_SRA, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
            {c_SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
            {c_SRL, 32'hF000_0000, 32'h0000_001C, 32'h0000_000F},
            {c_SRA, 32'h7000_0000, 32'h0000_0003, 32'h0E00_0000}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_BARREL_SHIFT_EN
            lat = 1;
`else
            lat = int'(tbl[i].b[4:0]) + 1;
`endif
            issue(tbl[i].ctrl, tbl[i].a, tbl[i].b, 5'(20 + i), w);
            edges    = 1;
            busy_cnt = 0;
            rdy_bad  = 0;
            while (!bus.out_valid && edges < 100) begin
                if (bus.busy) busy_cnt++;
                if (bus.in_ready) rdy_bad++;
                step();
                edges++;
            end
            n_checks++;
            if (edges !== lat || busy_cnt !== lat - 1 || rdy_bad !== 0) begin
                n_fail++;
                $display("FAIL shift_%0d_timing: got lat %0d busy %0d rdy %0d, required %0d %0d 0",
                         i, edges, busy_cnt, rdy_bad, lat, lat - 1);
            end
            n_checks++;
            if (bus.out_result !== tbl[i].exp || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_%0d_result: got %h busy%b, required %h busy0", i,
                         bus.out_result, bus.busy, tbl[i].exp);
            end
        end
    endtask

    task automatic test_back_pressure();
        int w;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        issue(c_ADD, 32'd100, 32'd23, 5'd7, w);
        bus.in_valid    = 1'b1;
        bus.in_alu_ctrl = c_XOR;
        bus.in_op_a     = 32'h0000_FF00;
        bus.in_op_b     = 32'h0000_0FF0;
        bus.in_rd       = 5'd9;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_result !== 32'd123 || bus.out_rd !== 5'd7) begin
                n_fail++;
                $display("FAIL hold_%0d: got rdy%b v%b %h rd%0d, required rdy0 v1 0000007b rd7",
                         k, bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd);
            end
            step();
        end
        bus.out_ready = 1'b1;
        issue(c_XOR, 32'h0000_FF00, 32'h0000_0FF0, 5'd9, w);
        n_checks++;
        if (w !== 0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_F0F0) begin
            n_fail++;
            $display("FAIL release: got wait %0d v%b %h, required wait 0 v1 0000f0f0",
                     w, bus.out_valid, bus.out_result);
        end
    endtask

    task automatic test_back_to_back();
        int         w, stalls;
        logic [3:0] ops [7] = '{c_ADD, c_SUB, c_SLT, c_SLTU, c_XOR, c_OR, c_AND};
        bus.out_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            issue(ops[$urandom_range(0, 6)], $urandom, $urandom, 5'($urandom_range(0, 31)), w);
            stalls += w;
        end
        n_checks++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d stall cycles, required 0", stalls);
        end
    endtask

    task automatic test_random_mix();
        int         w;
        logic [3:0] ops [10] = '{c_ADD, c_SUB, c_SLL, c_SLT, c_SLTU, c_XOR, c_SRL, c_SRA,
                                 c_OR, c_AND};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            issue(ops[$urandom_range(0, 9)], $urandom, $urandom, 5'($urandom_range(0, 31)), w);
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    endtask

    task automatic test_reset_mid_shift();
`ifndef ALU_BARREL_SHIFT_EN
        int w;
        bus.out_ready = 1'b1;
        issue(c_SLL, 32'h0000_0003, 32'd20, 5'd3, w);
        repeat (10) step();
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_busy: got %b, required 1", bus.busy);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shift_reset: got v%b busy%b rdy%b, required 0 0 0",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        exp_q.delete();
        rst = 1'b0;
        issue(c_ADD, 32'd2, 32'd2, 5'd4, w);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd4 || bus.out_rd !== 5'd4) begin
            n_fail++;
            $display("FAIL post_reset_add: got v%b %h rd%0d, required v1 00000004 rd4",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
        repeat (25) step();
`endif
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_alu_ctrl = 4'd0;
        bus.in_op_a     = 32'd0;
        bus.in_op_b     = 32'd0;
        bus.in_rd       = 5'd0;
        bus.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_ops();
        test_shift();
        test_back_pressure();
        test_back_to_back();
        test_random_mix();
        test_reset_mid_shift();
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
